// File: rtl/rf_write_arbiter_if.sv
// Bundle of the register-file write arbiter's port A, port B, hazard-check and
// register-file write-port signals, seen from the arbiter (slave) or the pipeline (master).
interface rf_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32
);
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_wa;
  logic [WORD_WIDTH-1:0] a_wd;
  logic                  b_valid;
  logic [ADDR_WIDTH-1:0] b_wa;
  logic [WORD_WIDTH-1:0] b_wd;
  logic                  b_ready;
  logic [ADDR_WIDTH-1:0] ra1;
  logic [ADDR_WIDTH-1:0] ra2;
  logic                  busy1;
  logic                  busy2;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_wa;
  logic [WORD_WIDTH-1:0] rf_wd;
  logic                  stall_req;

  modport slave (
    input  a_we, a_wa, a_wd, b_valid, b_wa, b_wd, ra1, ra2,
    output b_ready, busy1, busy2, rf_we, rf_wa, rf_wd, stall_req
  );

  modport master (
    output a_we, a_wa, a_wd, b_valid, b_wa, b_wd, ra1, ra2,
    input  b_ready, busy1, busy2, rf_we, rf_wa, rf_wd, stall_req
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares one register-file write port between pipeline writeback (A, always wins)
// and a 2-deep queue of multi-cycle unit writes (B), requesting a stall when B starves.
module rf_write_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_STALL} state_t;

  localparam logic [3:0] LP_LAST = 4'(MAX_WAIT - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_wcnt;
  logic [3:0]            w_wcnt_nxt;
  logic                  r_stall;
  logic [1:0]            r_vld;
  logic [1:0]            w_vld_nxt;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [ADDR_WIDTH-1:0] r_wa [2];
  logic [WORD_WIDTH-1:0] r_wd [2];
  logic                  w_full;
  logic                  w_empty;
  logic                  w_empty_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_a_wr;
  logic                  w_busy1;
  logic                  w_busy2;

  assign w_full      = &r_vld;
  assign w_empty     = ~|r_vld;
  assign w_a_wr      = bus.a_we & (bus.a_wa != '0);
  assign w_push      = bus.b_valid & ~w_full & (bus.b_wa != '0);
  assign w_pop       = ~w_empty & ~w_a_wr;
  assign w_empty_nxt = ~|w_vld_nxt;

  always_comb begin
    w_vld_nxt = r_vld;
    if (w_pop)  w_vld_nxt[r_rptr] = 1'b0;
    if (w_push) w_vld_nxt[r_wptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
    end else begin
      r_vld <= w_vld_nxt;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
    end
  end

  // Queue payload carries no reset; validity lives entirely in r_vld.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wa[r_wptr] <= bus.b_wa;
      r_wd[r_wptr] <= bus.b_wd;
    end
  end

  always_comb begin
    w_busy1 = 1'b0;
    w_busy2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (r_vld[i] && (r_wa[i] == bus.ra1) && (bus.ra1 != '0)) w_busy1 = 1'b1;
      if (r_vld[i] && (r_wa[i] == bus.ra2) && (bus.ra2 != '0)) w_busy2 = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !w_empty_nxt) begin
          w_state_nxt = ST_WAIT;
          w_wcnt_nxt  = '0;
        end
      end
      ST_WAIT, ST_STALL: begin
        if (w_pop || w_empty) begin
          w_state_nxt = w_empty_nxt ? ST_IDLE : ST_WAIT;
          w_wcnt_nxt  = '0;
        end else if (r_state == ST_WAIT) begin
          if (r_wcnt == LP_LAST) w_state_nxt = ST_STALL;
          else                   w_wcnt_nxt  = r_wcnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_stall <= (w_state_nxt == ST_STALL);
    end
  end

  always_comb begin
    bus.rf_we = 1'b0;
    bus.rf_wa = '0;
    bus.rf_wd = '0;
    if (w_a_wr) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = bus.a_wa;
      bus.rf_wd = bus.a_wd;
    end else if (w_pop) begin
      bus.rf_we = 1'b1;
      bus.rf_wa = r_wa[r_rptr];
      bus.rf_wd = r_wd[r_rptr];
    end
  end

  assign bus.b_ready   = ~w_full;
  assign bus.busy1     = w_busy1;
  assign bus.busy2     = w_busy2;
  assign bus.stall_req = r_stall;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: reset, single drain, stall
// under sustained port A traffic, dropped zero-address writes, hazards and reset mid-queue.
module tb_rf_write_arbiter;

  logic clk;
  logic rst_n;
  int   nCompared;
  int   nMismatched;

  rf_write_arbiter_if #(.ADDR_WIDTH(5), .WORD_WIDTH(32)) bus ();

  rf_write_arbiter #(.ADDR_WIDTH(5), .WORD_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_we    = 1'b0;
    bus.a_wa    = '0;
    bus.a_wd    = '0;
    bus.b_valid = 1'b0;
    bus.b_wa    = '0;
    bus.b_wd    = '0;
    bus.ra1     = '0;
    bus.ra2     = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    nCompared++; if (bus.b_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_b_ready: got %0h expected 1", bus.b_ready); end
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rf_we: got %0h expected 0", bus.rf_we); end
    nCompared++; if (bus.stall_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_stall_req: got %0h expected 0", bus.stall_req); end
    nCompared++; if ({bus.busy1, bus.busy2} !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_busy: got %0b expected 00", {bus.busy1, bus.busy2}); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    nCompared++; if (bus.b_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_reset_b_ready: got %0h expected 1", bus.b_ready); end
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL post_reset_rf_we: got %0h expected 0", bus.rf_we); end
  endtask

  task automatic test_single_push();
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd3;
    bus.b_wd    = 32'hAAAA_0003;
    #1;
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_no_passthru: got %0h expected 0", bus.rf_we); end
    tick();
    bus.b_valid = 1'b0;
    #1;
    nCompared++; if (bus.rf_we !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_rf_we: got %0h expected 1", bus.rf_we); end
    nCompared++; if (bus.rf_wa !== 5'd3) begin nMismatched++; $display("[TB] FAIL single_rf_wa: got %0h expected 3", bus.rf_wa); end
    nCompared++; if (bus.rf_wd !== 32'hAAAA_0003) begin nMismatched++; $display("[TB] FAIL single_rf_wd: got %0h expected aaaa0003", bus.rf_wd); end
    tick();
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_drained: got %0h expected 0", bus.rf_we); end
    nCompared++; if (bus.stall_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_stall_req: got %0h expected 0", bus.stall_req); end
  endtask

  task automatic test_stall();
    bus.a_we    = 1'b1;
    bus.a_wa    = 5'd5;
    bus.a_wd    = 32'h5555_0005;
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd7;
    bus.b_wd    = 32'h7777_0007;
    #1;
    nCompared++; if (bus.rf_wa !== 5'd5) begin nMismatched++; $display("[TB] FAIL stall_a_wins: got %0h expected 5", bus.rf_wa); end
    tick();
    bus.b_wa = 5'd8;
    bus.b_wd = 32'h8888_0008;
    tick();
    bus.b_valid = 1'b0;
    bus.ra1     = 5'd7;
    bus.ra2     = 5'd8;
    #1;
    nCompared++; if (bus.b_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_full_b_ready: got %0h expected 0", bus.b_ready); end
    nCompared++; if ({bus.busy1, bus.busy2} !== 2'b11) begin nMismatched++; $display("[TB] FAIL stall_busy: got %0b expected 11", {bus.busy1, bus.busy2}); end
    tick();
    tick();
    tick();
    nCompared++; if (bus.stall_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_early: got %0h expected 0", bus.stall_req); end
    tick();
    nCompared++; if (bus.stall_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_asserted: got %0h expected 1", bus.stall_req); end
    nCompared++; if (bus.rf_wd !== 32'h5555_0005) begin nMismatched++; $display("[TB] FAIL stall_a_still_wins: got %0h expected 55550005", bus.rf_wd); end
    tick();
    nCompared++; if (bus.stall_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_held: got %0h expected 1", bus.stall_req); end
    bus.a_we = 1'b0;
    #1;
    nCompared++; if (bus.rf_wa !== 5'd7) begin nMismatched++; $display("[TB] FAIL stall_drain_first_wa: got %0h expected 7", bus.rf_wa); end
    nCompared++; if (bus.rf_wd !== 32'h7777_0007) begin nMismatched++; $display("[TB] FAIL stall_drain_first_wd: got %0h expected 77770007", bus.rf_wd); end
    tick();
    nCompared++; if (bus.stall_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_released: got %0h expected 0", bus.stall_req); end
    nCompared++; if (bus.rf_wa !== 5'd8) begin nMismatched++; $display("[TB] FAIL stall_drain_second_wa: got %0h expected 8", bus.rf_wa); end
    nCompared++; if (bus.b_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_b_ready_back: got %0h expected 1", bus.b_ready); end
    tick();
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_all_drained: got %0h expected 0", bus.rf_we); end
    nCompared++; if (bus.stall_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_final: got %0h expected 0", bus.stall_req); end
    idle_inputs();
  endtask

  task automatic test_drop_zero();
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd0;
    bus.b_wd    = 32'hDEAD_BEEF;
    #1;
    nCompared++; if (bus.b_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL zero_b_ready: got %0h expected 1", bus.b_ready); end
    tick();
    bus.b_valid = 1'b0;
    #1;
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL zero_no_write: got %0h expected 0", bus.rf_we); end
    nCompared++; if ({bus.busy1, bus.busy2} !== 2'b00) begin nMismatched++; $display("[TB] FAIL zero_busy: got %0b expected 00", {bus.busy1, bus.busy2}); end
    bus.a_we = 1'b1;
    bus.a_wa = 5'd0;
    bus.a_wd = 32'h1234_5678;
    #1;
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL zero_a_no_write: got %0h expected 0", bus.rf_we); end
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd4;
    bus.b_wd    = 32'h4444_0004;
    tick();
    bus.b_valid = 1'b0;
    #1;
    nCompared++; if (bus.rf_wa !== 5'd4) begin nMismatched++; $display("[TB] FAIL zero_a_frees_slot: got %0h expected 4", bus.rf_wa); end
    nCompared++; if (bus.rf_we !== 1'b1) begin nMismatched++; $display("[TB] FAIL zero_a_frees_slot_we: got %0h expected 1", bus.rf_we); end
    tick();
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL zero_drained: got %0h expected 0", bus.rf_we); end
    idle_inputs();
  endtask

  task automatic test_busy();
    bus.a_we    = 1'b1;
    bus.a_wa    = 5'd2;
    bus.a_wd    = 32'h2222_0002;
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd9;
    bus.b_wd    = 32'h9999_0009;
    tick();
    bus.b_valid = 1'b0;
    bus.ra1     = 5'd9;
    bus.ra2     = 5'd0;
    #1;
    nCompared++; if (bus.busy1 !== 1'b1) begin nMismatched++; $display("[TB] FAIL busy_ra1: got %0h expected 1", bus.busy1); end
    nCompared++; if (bus.busy2 !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_ra2_zero: got %0h expected 0", bus.busy2); end
    bus.a_we = 1'b0;
    #1;
    nCompared++; if (bus.rf_wa !== 5'd9) begin nMismatched++; $display("[TB] FAIL busy_drain_wa: got %0h expected 9", bus.rf_wa); end
    tick();
    nCompared++; if (bus.busy1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL busy_cleared: got %0h expected 0", bus.busy1); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.a_we    = 1'b1;
    bus.a_wa    = 5'd5;
    bus.a_wd    = 32'h5555_0005;
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd10;
    bus.b_wd    = 32'hAAAA_000A;
    tick();
    bus.b_wa = 5'd11;
    bus.b_wd = 32'hBBBB_000B;
    tick();
    bus.b_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    nCompared++; if (bus.stall_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_pre_stall: got %0h expected 1", bus.stall_req); end
    rst_n    = 1'b0;
    bus.a_we = 1'b0;
    bus.ra1  = 5'd10;
    bus.ra2  = 5'd11;
    #1;
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_rf_we: got %0h expected 0", bus.rf_we); end
    nCompared++; if (bus.b_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_b_ready: got %0h expected 1", bus.b_ready); end
    nCompared++; if (bus.stall_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_stall_req: got %0h expected 0", bus.stall_req); end
    nCompared++; if ({bus.busy1, bus.busy2} !== 2'b00) begin nMismatched++; $display("[TB] FAIL rstmid_busy: got %0b expected 00", {bus.busy1, bus.busy2}); end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_no_b_write cycle %0d: got %0h expected 0", i, bus.rf_we); end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bus.b_valid = 1'b1;
    bus.b_wa    = 5'd12;
    bus.b_wd    = 32'hCCCC_000C;
    tick();
    bus.b_wa = 5'd13;
    bus.b_wd = 32'hDDDD_000D;
    #1;
    nCompared++; if (bus.rf_wa !== 5'd12) begin nMismatched++; $display("[TB] FAIL b2b_first_wa: got %0h expected c", bus.rf_wa); end
    nCompared++; if (bus.b_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_b_ready: got %0h expected 1", bus.b_ready); end
    tick();
    bus.b_valid = 1'b0;
    bus.ra1     = 5'd13;
    bus.ra2     = 5'd12;
    #1;
    nCompared++; if (bus.rf_wa !== 5'd13) begin nMismatched++; $display("[TB] FAIL b2b_second_wa: got %0h expected d", bus.rf_wa); end
    nCompared++; if (bus.rf_wd !== 32'hDDDD_000D) begin nMismatched++; $display("[TB] FAIL b2b_second_wd: got %0h expected dddd000d", bus.rf_wd); end
    nCompared++; if ({bus.busy1, bus.busy2} !== 2'b10) begin nMismatched++; $display("[TB] FAIL b2b_occupancy: got %0b expected 10", {bus.busy1, bus.busy2}); end
    tick();
    nCompared++; if (bus.rf_we !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_drained: got %0h expected 0", bus.rf_we); end
    nCompared++; if (bus.busy1 !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_busy_cleared: got %0h expected 0", bus.busy1); end
    idle_inputs();
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_single_push();
    test_stall();
    test_drop_zero();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter MAX_WAIT, default 4, range 1-15, cycles a queued B write may wait before stall is requested.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; reset input 1, async active-low.
REQ-005 SHALL have a_we input 1, pipeline writeback write enable (port A, never back-pressured).
REQ-006 SHALL have a_wa input ADDR_WIDTH, and a_wd input WORD_WIDTH, which are the port A address and data.
REQ-007 SHALL have b_valid input 1, b_wa input ADDR_WIDTH, and b_wd input WORD_WIDTH, which are the multi-cycle unit write request (port B).
REQ-008 SHALL have b_ready output 1, port B accept; a transfer occurs on a rising edge with b_valid=1 and b_ready=1.
REQ-009 SHALL have ra1 and ra2 inputs of ADDR_WIDTH, which are decode-stage read addresses to check against pending B writes.
REQ-010 SHALL have busy1 and busy2 outputs of 1 bit; busy1 is 1 when ra1 has a pending queued B write, and busy2 is the same for ra2.
REQ-011 SHALL have rf_we output 1, rf_wa output ADDR_WIDTH, and rf_wd output WORD_WIDTH, which drive the single register file write port.
REQ-012 SHALL have stall_req output 1, registered request to the pipeline to hold port A idle.

Function
REQ-013 SHALL hold port B writes in a 2-entry FIFO with in-order drain; b_ready = FIFO not full.
REQ-014 SHALL drop a port B transfer with b_wa=0: handshake completes and nothing is pushed.
REQ-015 SHALL treat a_we=1 with a_wa=0 as no write: rf_we stays 0 and the write slot is free for B.
REQ-016 SHALL give port A absolute priority: a_we=1 with a_wa!=0 drives rf_we=1, rf_wa=a_wa, and rf_wd=a_wd in the same cycle, combinationally.
REQ-017 SHALL pop the FIFO head (pop=1) when the FIFO is non-empty and port A is not writing; rf_we=1, rf_wa=head address, and rf_wd=head data, combinationally.
REQ-018 SHALL drive rf_we=0 and rf_wa/rf_wd=0 when neither A nor B writes.
REQ-019 SHALL make the earliest drain of a pushed entry the cycle after its accepting edge; there is no same-cycle pass-through.
REQ-020 SHALL process push and pop in the same cycle when not full: the occupancy count is unchanged and order is preserved.
REQ-021 SHALL NOT push when full, even if a pop occurs that cycle, because b_ready=0 while full.
REQ-022 SHALL set busy1 = OR over valid entries of (entry address == ra1 and ra1 != 0); busy2 likewise for ra2; both are combinational.
REQ-023 SHALL implement a 3-state FSM, IDLE/WAIT/STALL, with a wait counter wcnt of 4 bits.
REQ-024 SHALL transition from IDLE to WAIT on the edge after the FIFO becomes non-empty, with wcnt=0.
REQ-025 In WAIT, SHALL increment wcnt on each edge where the FIFO is non-empty and no pop occurred; when that edge sees wcnt==MAX_WAIT-1, it SHALL go to STALL.
REQ-026 In WAIT or STALL, on an edge with a pop, SHALL go to IDLE if the FIFO becomes empty, else to WAIT with wcnt=0.
REQ-027 SHALL assert stall_req=1 exactly while in STALL; the output is registered from the state.
REQ-028 If a_we=1 during STALL, port A SHALL still win, with no error; the FSM SHALL remain in STALL.
REQ-029 SHALL order a port A write to an address matching a queued B entry A first, then B; the hazard is the pipeline's responsibility via busy1/busy2.

Reset
REQ-030 On reset low, SHALL asynchronously empty the FIFO and set FSM=IDLE, wcnt=0, and stall_req=0.
REQ-031 During and right after reset, SHALL drive b_ready=1, busy1=busy2=0, and rf_we=0.
REQ-032 On reset mid-operation, SHALL discard queued B entries without writing them.
REQ-033 SHALL hold no reset value on FIFO data storage; only valid bits, pointers, FSM, and wcnt are reset.

Verification
REQ-034 Scenario: A idle, one B push (wa=3, wd=0xAAAA0003) -> next cycle rf_we=1, rf_wa=3, rf_wd=0xAAAA0003; FIFO empty after; stall_req stays 0.
REQ-035 Scenario: A writes (wa=5) every cycle, two B pushes (wa=7, wa=8) -> b_ready=0 after the 2nd push; stall_req=1 after 4 waiting edges; drop a_we -> wa=7 then wa=8 written; stall_req returns to 0.
REQ-036 Scenario: B push with b_wa=0 -> accepted, no rf_we, and busy1/busy2 stay 0.
REQ-037 Scenario: queued B wa=9, ra1=9, ra2=0 -> busy1=1 and busy2=0; after drain, busy1=0.
REQ-038 Scenario: full FIFO under A writes, then reset pulse -> rf_we=0, b_ready=1, stall_req=0, and no B write ever appears.
REQ-039 Scenario: push and pop in the same cycle with 1 entry queued -> occupancy stays 1, and entries are written in push order.
